// File: rtl/addr_bank_mapper.sv
// addr_bank_mapper: sequences one address request through the divide-by-three
// unit and turns quotient/remainder into a NoC request
// (bank = remainder, bank-local address = quotient).
// The divider must not see a new start pulse in the cycle right after its
// result, so every transaction ends with a one-cycle GAP state.
module addr_bank_mapper #(
    parameter int ADDR_WIDTH = 20,
    parameter int ID_WIDTH   = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // request source
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic                  req_wr,
    // divider
    output logic                  div_vld_in,
    output logic [ADDR_WIDTH-1:0] div_data_in,
    input  logic [ADDR_WIDTH-1:0] div_quotient,
    input  logic [1:0]            div_reminder,
    input  logic                  div_vld_out,
    // NoC request
    output logic                  noc_vld,
    input  logic                  noc_rdy,
    output logic [1:0]            noc_dest,
    output logic [ADDR_WIDTH-1:0] noc_local_addr,
    output logic [ID_WIDTH-1:0]   noc_id,
    output logic                  noc_wr,
    // status
    output logic                  err_timeout,
    output logic                  busy
);

    // Counter must hold TIMEOUT: it increments once more on the edge that leaves WAIT.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      wait_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  wr_q;
    logic [1:0]            dest_q;
    logic [ADDR_WIDTH-1:0] local_q;
    logic                  res_take;
    logic                  res_bad;
    logic                  to_hit;

    // Remainder 3 cannot come from a correct divide-by-three; map it to bank 0.
    function automatic logic [1:0] bank_sel(input logic [1:0] rem);
        return (rem == 2'd3) ? 2'd0 : rem;
    endfunction

    // A result pulse only counts while waiting; it beats a same-cycle timeout.
    assign res_take = (state_q == S_WAIT) && div_vld_out;
    assign res_bad  = res_take && (div_reminder == 2'd3);
    assign to_hit   = (state_q == S_WAIT) && !div_vld_out && (wait_cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_vld) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_vld_out) begin
                    state_d = S_HOLD;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d = S_GAP;
                end
            end
            S_HOLD: begin
                if (noc_rdy) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the state register (err also sees the result pulse)
    always_comb begin
        req_rdy     = 1'b0;
        div_vld_in  = 1'b0;
        noc_vld     = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_rdy = 1'b1;
                busy    = 1'b0;
            end
            S_LAUNCH: begin
                div_vld_in = 1'b1;
            end
            S_HOLD: begin
                noc_vld = 1'b1;
            end
            default: begin
            end
        endcase
        err_timeout = to_hit || res_bad;
    end

    // Request capture: address, ID and direction are latched at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            id_q   <= '0;
            wr_q   <= 1'b0;
        end else if ((state_q == S_IDLE) && req_vld) begin
            addr_q <= req_addr;
            id_q   <= req_id;
            wr_q   <= req_wr;
        end
    end

    // Wait counter: cleared in LAUNCH, counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Result capture: quotient and bank index are frozen for the HOLD phase
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_q  <= 2'd0;
            local_q <= '0;
        end else if (res_take) begin
            dest_q  <= bank_sel(div_reminder);
            local_q <= div_quotient;
        end
    end

    assign div_data_in    = addr_q;
    assign noc_dest       = dest_q;
    assign noc_local_addr = local_q;
    assign noc_id         = id_q;
    assign noc_wr         = wr_q;

endmodule

// File: tb/tb_addr_bank_mapper.sv
// Bench for addr_bank_mapper: behavioural divide-by-three model, table of
// single requests, scoreboard on the NoC side, and hand-written sequences for
// backpressure, back-to-back, timeout, bad remainder and mid-flight reset.
module tb_addr_bank_mapper;

    localparam int AW = 20;
    localparam int IW = 4;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_vld;
    logic          req_rdy;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] req_id;
    logic          req_wr;
    logic          div_vld_in;
    logic [AW-1:0] div_data_in;
    logic [AW-1:0] div_quotient;
    logic [1:0]    div_reminder;
    logic          div_vld_out = 1'b0;
    logic          noc_vld;
    logic          noc_rdy;
    logic [1:0]    noc_dest;
    logic [AW-1:0] noc_local_addr;
    logic [IW-1:0] noc_id;
    logic          noc_wr;
    logic          err_timeout;
    logic          busy;

    addr_bank_mapper #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_id(req_id), .req_wr(req_wr),
        .div_vld_in(div_vld_in), .div_data_in(div_data_in), .div_quotient(div_quotient),
        .div_reminder(div_reminder), .div_vld_out(div_vld_out),
        .noc_vld(noc_vld), .noc_rdy(noc_rdy), .noc_dest(noc_dest), .noc_local_addr(noc_local_addr),
        .noc_id(noc_id), .noc_wr(noc_wr), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: result pulse AW+1 cycles after the start cycle.
    logic          mute = 1'b0;
    logic          rem3 = 1'b0;
    logic          inj  = 1'b0;
    logic [AW-1:0] m_data = '0;
    int            dcnt = 0;
    always @(posedge clk) begin
        div_vld_out <= inj;
        if (div_vld_in) begin
            dcnt   <= AW;
            m_data <= div_data_in;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !mute) div_vld_out <= 1'b1;
        end
    end
    assign div_quotient = AW'(m_data / 3);
    assign div_reminder = rem3 ? 2'd3 : 2'(m_data % 3);

    typedef struct packed {
        logic [1:0]    dest;
        logic [AW-1:0] la;
        logic [IW-1:0] id;
        logic          wr;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          wr;
        logic [1:0]    dest;
        logic [AW-1:0] la;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: scoreboard pops, result/start spacing, accept spacing, error log.
    int   hs_cnt   = 0;
    int   err_cnt  = 0;
    int   last_err = -1;
    int   prev_acc = -1;
    bit   chk_gap  = 1'b0;
    logic prev_dvo = 1'b0;
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (noc_vld && noc_rdy) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    check("noc_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("noc_fields", {noc_dest, noc_local_addr, noc_id, noc_wr}, mon_e);
                end
            end
            if (div_vld_in) check("start_after_result", prev_dvo, 0);
            if (err_timeout) begin
                err_cnt++;
                last_err = cyc;
            end
            if (req_vld && req_rdy) begin
                if (chk_gap && prev_acc >= 0) check("accept_gap", (cyc - prev_acc) >= AW + 4, 1);
                prev_acc = cyc;
            end
        end
        prev_dvo = div_vld_out;
    end

    // Presents a request and returns in the cycle after acceptance.
    task automatic do_req(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic wr, output int t_acc);
        int n = 0;
        req_addr = a;
        req_id   = id;
        req_wr   = wr;
        req_vld  = 1'b1;
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) check("accept_wait", 0, 1);
        t_acc = cyc;
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic wait_noc(output int tn);
        int n = 0;
        while (!noc_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!noc_vld) check("noc_wait", 0, 1);
        tn = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) check("idle_wait", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vec[6];
    exp_t b2b[3];
    int   t, tn, h0, e0, bad, n;
    exp_t snap;

    initial begin
        vec[0] = '{20'h0000A, 4'd3, 1'b1, 2'd1, 20'h00003};
        vec[1] = '{20'hFFFFF, 4'd5, 1'b0, 2'd0, 20'h55555};
        vec[2] = '{20'h00000, 4'd0, 1'b0, 2'd0, 20'h00000};
        vec[3] = '{20'h00007, 4'd1, 1'b1, 2'd1, 20'h00002};
        vec[4] = '{20'h12345, 4'hF, 1'b1, 2'd0, 20'h06117};
        vec[5] = '{20'h00005, 4'd9, 1'b0, 2'd2, 20'h00001};
        b2b[0] = '{2'd1, 20'h00002, 4'd0, 1'b0};
        b2b[1] = '{2'd2, 20'h00002, 4'd1, 1'b1};
        b2b[2] = '{2'd0, 20'h00003, 4'd2, 1'b0};

        req_vld = 1'b0; req_addr = '0; req_id = '0; req_wr = 1'b0; noc_rdy = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", req_rdy, 1);
        check("rst_busy", busy, 0);
        check("rst_noc_vld", noc_vld, 0);
        check("rst_div_vld_in", div_vld_in, 0);
        check("rst_err", err_timeout, 0);
        check("rst_noc_fields", {noc_dest, noc_local_addr, noc_id, noc_wr}, 0);
        check("rst_div_data", div_data_in, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single requests with noc_rdy held high
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{vec[i].dest, vec[i].la, vec[i].id, vec[i].wr});
            do_req(vec[i].addr, vec[i].id, vec[i].wr, t);
            check("launch_pulse", div_vld_in, 1);
            check("launch_operand", div_data_in, vec[i].addr);
            check("launch_rdy_low", req_rdy, 0);
            @(negedge clk);
            check("launch_single", div_vld_in, 0);
            wait_noc(tn);
            check("noc_latency", tn - t, AW + 3);
            @(negedge clk);
            wait_idle();
        end

        // Backpressure in HOLD
        noc_rdy = 1'b0;
        sb.push_back('{2'd1, 20'h00005, 4'd6, 1'b0});
        do_req(20'h00010, 4'd6, 1'b0, t);
        wait_noc(tn);
        snap = {noc_dest, noc_local_addr, noc_id, noc_wr};
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!noc_vld || ({noc_dest, noc_local_addr, noc_id, noc_wr} != snap) || req_rdy || !busy) bad++;
            @(negedge clk);
        end
        check("bp_stable", bad, 0);
        h0 = hs_cnt;
        noc_rdy = 1'b1;
        @(negedge clk);
        check("bp_one_transfer", hs_cnt - h0, 1);
        check("bp_vld_dropped", noc_vld, 0);
        check("bp_gap_rdy_low", req_rdy, 0);
        @(negedge clk);
        check("bp_idle_rdy", req_rdy, 1);

        // Back-to-back requests held continuously
        chk_gap = 1'b1;
        prev_acc = -1;
        req_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(b2b[i]);
            req_addr = AW'(7 + i);
            req_id   = IW'(i);
            req_wr   = b2b[i].wr;
            n = 0;
            while (!req_rdy && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("b2b_accept", req_rdy, 1);
            @(negedge clk);
        end
        req_vld = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drained", sb.size(), 0);
        chk_gap = 1'b0;
        wait_idle();

        // Divider never answers
        mute = 1'b1;
        h0 = hs_cnt;
        e0 = err_cnt;
        do_req(20'h00020, 4'd2, 1'b1, t);
        bad = 0;
        while (cyc < t + TO + 1) begin
            if (err_timeout) bad++;
            @(negedge clk);
        end
        check("to_no_early", bad, 0);
        check("to_pulse", err_timeout, 1);
        @(negedge clk);
        check("to_pulse_single", err_timeout, 0);
        check("to_gap_rdy", req_rdy, 0);
        @(negedge clk);
        check("to_rdy_back", req_rdy, 1);
        check("to_err_count", err_cnt - e0, 1);
        check("to_no_noc", hs_cnt - h0, 0);
        mute = 1'b0;

        // Remainder 3 from the divider
        rem3 = 1'b1;
        sb.push_back('{2'd0, 20'h00003, 4'd4, 1'b0});
        do_req(20'h00009, 4'd4, 1'b0, t);
        e0 = err_cnt;
        wait_noc(tn);
        check("rem3_dest", noc_dest, 0);
        check("rem3_err_cycle", last_err, t + AW + 2);
        check("rem3_err_count", err_cnt - e0, 1);
        @(negedge clk);
        rem3 = 1'b0;
        wait_idle();

        // Reset while in WAIT; the divider's later pulse must be ignored
        h0 = hs_cnt;
        do_req(20'h00010, 4'd7, 1'b1, t);
        repeat (8) @(negedge clk);
        check("rw_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_noc_vld", noc_vld, 0);
        check("rw_busy", busy, 0);
        check("rw_req_rdy", req_rdy, 1);
        check("rw_div_vld_in", div_vld_in, 0);
        repeat (25) @(negedge clk);
        check("rw_no_output", hs_cnt - h0, 0);
        sb.push_back('{2'd1, 20'h00005, 4'd7, 1'b1});
        do_req(20'h00010, 4'd7, 1'b1, t);
        wait_noc(tn);
        check("rw_next_latency", tn - t, AW + 3);
        @(negedge clk);
        wait_idle();

        // Reset while in HOLD, then a stray result pulse in IDLE
        noc_rdy = 1'b0;
        h0 = hs_cnt;
        do_req(20'h0000B, 4'd8, 1'b0, t);
        wait_noc(tn);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rh_noc_vld", noc_vld, 0);
        check("rh_busy", busy, 0);
        check("rh_req_rdy", req_rdy, 1);
        noc_rdy = 1'b1;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        repeat (5) @(negedge clk);
        check("rh_no_output", hs_cnt - h0, 0);
        check("rh_idle", busy, 0);
        sb.push_back('{2'd2, 20'h00003, 4'd8, 1'b0});
        do_req(20'h0000B, 4'd8, 1'b0, t);
        wait_noc(tn);
        check("rh_next_latency", tn - t, AW + 3);
        @(negedge clk);
        wait_idle();

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
